// File: rtl/fpu_divider_seq.sv
// fpu_divider_seq
//   Iterative IEEE-754 single-precision divider (floating1_in / floating2_in).
//   Radix-2 restoring mantissa division, one quotient bit per clock.
//   Results are truncated (round toward zero), and denormal inputs are
//   flushed to zero. Latency is fixed: special cases also run the full
//   division.
//
// Ports
//   clk                   : clock, rising edge
//   rst_n                 : asynchronous active-low reset
//   start_in              : operand-valid strobe, sampled only while idle
//   floating1_in          : dividend
//   floating2_in          : divisor
//   busy_out              : high from the cycle after start is accepted until done
//   done_out              : one-cycle pulse, result valid in that cycle
//   floating_division_out : registered quotient, held until the next done
module fpu_divider_seq #(
  parameter int D_WIDTH = 32,
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int BIAS    = 127
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_in,
  input  logic [D_WIDTH-1:0] floating1_in,
  input  logic [D_WIDTH-1:0] floating2_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [D_WIDTH-1:0] floating_division_out
);

  localparam int Q_W   = M_WIDTH + 2;       // quotient bits
  localparam int R_W   = M_WIDTH + 3;       // remainder bits
  localparam int EXP_W = E_WIDTH + 2;       // signed exponent arithmetic
  localparam int CNT_W = $clog2(Q_W);

  localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(2**E_WIDTH - 1);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [D_WIDTH-1:0] QNAN =
    {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(M_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t   state, state_next;
  special_t spec_r, spec_in;

  logic                    sign_r;
  logic signed [EXP_W-1:0] exp_r;
  logic [R_W-1:0]          rem_r;
  logic [M_WIDTH:0]        div_r;
  logic [Q_W-1:0]          quo_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [D_WIDTH-1:0]      result_r;

  // Operand field decode
  logic               s1, s2;
  logic [E_WIDTH-1:0] e1, e2;
  logic [M_WIDTH-1:0] m1, m2;
  logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic signed [EXP_W-1:0] exp_in;

  always_comb begin
    s1 = floating1_in[D_WIDTH-1];
    s2 = floating2_in[D_WIDTH-1];
    e1 = floating1_in[D_WIDTH-2 -: E_WIDTH];
    e2 = floating2_in[D_WIDTH-2 -: E_WIDTH];
    m1 = floating1_in[M_WIDTH-1:0];
    m2 = floating2_in[M_WIDTH-1:0];

    a_nan  = (e1 == '1) && (m1 != '0);
    a_inf  = (e1 == '1) && (m1 == '0);
    a_zero = (e1 == '0);
    b_nan  = (e2 == '1) && (m2 != '0);
    b_inf  = (e2 == '1) && (m2 == '0);
    b_zero = (e2 == '0);

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_in = SP_NAN;
    else if (a_inf || b_zero)
      spec_in = SP_INF;
    else if (a_zero || b_inf)
      spec_in = SP_ZERO;
    else
      spec_in = SP_NONE;

    exp_in = EXP_W'(e1) - EXP_W'(e2) + EXP_W'(BIAS);
  end

  // Restoring division step; the remainder stays below twice the divisor,
  // so a trial that does not borrow always fits back into R_W bits.
  logic [R_W:0]   trial;
  logic           trial_ok;
  logic [R_W-1:0] rem_next;
  logic [Q_W-1:0] quo_next;

  always_comb begin
    trial    = {1'b0, rem_r} - {{(R_W-M_WIDTH){1'b0}}, div_r};
    trial_ok = ~trial[R_W];
    rem_next = (trial_ok ? trial[R_W-1:0] : rem_r) << 1;
    quo_next = {quo_r[Q_W-2:0], trial_ok};
  end

  // Normalisation: quotient is in (2^23, 2^25), so at most one shift
  logic [M_WIDTH-1:0]      mant_n;
  logic signed [EXP_W-1:0] exp_n;
  logic [D_WIDTH-1:0]      norm_result;

  always_comb begin
    if (quo_r[Q_W-1]) begin
      mant_n = quo_r[Q_W-2:1];
      exp_n  = exp_r;
    end else begin
      mant_n = quo_r[M_WIDTH-1:0];
      exp_n  = exp_r - EXP_W'(1);
    end

    unique case (spec_r)
      SP_NAN:  norm_result = QNAN;
      SP_INF:  norm_result = {sign_r, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
      SP_ZERO: norm_result = {sign_r, {(D_WIDTH-1){1'b0}}};
      default: begin
        if (exp_n >= EXP_INF)
          norm_result = {sign_r, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
        else if (exp_n <= EXP_ZERO)
          norm_result = {sign_r, {(D_WIDTH-1){1'b0}}};
        else
          norm_result = {sign_r, exp_n[E_WIDTH-1:0], mant_n};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start_in) state_next = S_DIVIDE;
      S_DIVIDE: if (cnt_r == '0) state_next = S_NORM;
      S_NORM:   state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_out              = (state == S_DIVIDE) || (state == S_NORM);
    done_out              = (state == S_DONE);
    floating_division_out = result_r;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r   <= 1'b0;
      spec_r   <= SP_NONE;
      exp_r    <= '0;
      rem_r    <= '0;
      div_r    <= '0;
      quo_r    <= '0;
      cnt_r    <= '0;
      result_r <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_in) begin
            sign_r <= s1 ^ s2;
            spec_r <= spec_in;
            exp_r  <= exp_in;
            rem_r  <= {{(R_W-M_WIDTH-1){1'b0}}, 1'b1, m1};
            div_r  <= {1'b1, m2};
            quo_r  <= '0;
            cnt_r  <= CNT_W'(Q_W - 1);
          end
        end
        S_DIVIDE: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        S_NORM:  result_r <= norm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_divider_seq.sv
// Testbench for fpu_divider_seq: table of directed vectors plus handshake
// and mid-operation reset sequences.
module tb_fpu_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic [31:0] floating1_in = '0;
  logic [31:0] floating2_in = '0;
  logic        busy_out;
  logic        done_out;
  logic [31:0] floating_division_out;

  int checks = 0;
  int failures = 0;

  fpu_divider_seq #(
    .D_WIDTH(32),
    .E_WIDTH(8),
    .M_WIDTH(23),
    .BIAS(127)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start_in              (start_in),
    .floating1_in          (floating1_in),
    .floating2_in          (floating2_in),
    .busy_out              (busy_out),
    .done_out              (done_out),
    .floating_division_out (floating_division_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Start one operation and wait for done. lat counts rising edges after the
  // sampling edge until done_out is visible; done is then captured by the
  // following (27th) edge, so lat is 26 for a conforming design.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    lat = -1;
    res = 'x;
    @(negedge clk);
    floating1_in = a;
    floating2_in = b;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    floating1_in = 32'hDEADBEEF;   // changes after acceptance must not matter
    floating2_in = 32'h12345678;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done_out) begin
        lat = k;
        res = floating_division_out;
        break;
      end
    end
  endtask

  vec_t vecs[14];

  initial begin
    logic [31:0] res;
    int          lat;
    int          busy_cnt, done_cnt, first_busy, done_at;
    logic [31:0] held;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000}; // 6/2
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000}; // 1/1
    vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA}; // 1/3 truncated
    vecs[3]  = '{32'hC0000000, 32'h3F800000, 32'hC0000000}; // -2/1
    vecs[4]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000}; // -6/2
    vecs[5]  = '{32'hBF800000, 32'h00000000, 32'hFF800000}; // -1/0
    vecs[6]  = '{32'h00000000, 32'h40A00000, 32'h00000000}; // 0/5
    vecs[7]  = '{32'h00000000, 32'h00000000, 32'h7FC00000}; // 0/0
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000}; // inf/inf
    vecs[9]  = '{32'h3F800000, 32'h7F800000, 32'h00000000}; // 1/inf
    vecs[10] = '{32'h7F000000, 32'h00800000, 32'h7F800000}; // overflow
    vecs[11] = '{32'h00800000, 32'h7F000000, 32'h00000000}; // underflow
    vecs[12] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000}; // NaN operand
    vecs[13] = '{32'h7F800000, 32'hBF800000, 32'hFF800000}; // inf/-1

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy_out}, 32'h0);
    check("reset_done", {31'b0, done_out}, 32'h0);
    check("reset_out", floating_division_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].q);
      check($sformatf("vec%0d_latency", i), lat, 26);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), {31'b0, done_out}, 32'h0);
      check($sformatf("vec%0d_hold", i), floating_division_out, vecs[i].q);
    end

    // Handshake: second start during DIVIDE is ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    floating1_in = 32'h40C00000;
    floating2_in = 32'h40000000;
    start_in = 1'b1;
    busy_cnt = 0; done_cnt = 0; first_busy = -1; done_at = -1; held = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start_in = 1'b0;
      if (c == 4) begin
        start_in = 1'b1;
        floating1_in = 32'h3F800000;
        floating2_in = 32'h40400000;
      end
      if (c == 5) start_in = 1'b0;
      if (busy_out) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
      end
      if (done_out) begin
        done_cnt++;
        done_at = c;
        held = floating_division_out;
      end
    end
    check("hs_busy_cycles", busy_cnt, 26);
    check("hs_first_busy", first_busy, 0);
    check("hs_done_count", done_cnt, 1);
    check("hs_done_at", done_at, 26);
    check("hs_result", held, 32'h40400000);

    // Reset during DIVIDE aborts without a done pulse
    run_op(32'h3F800000, 32'h40400000, res, lat);
    check("pre_rst_result", res, 32'h3EAAAAAA);
    @(negedge clk);
    floating1_in = 32'h40C00000;
    floating2_in = 32'h40000000;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy_out}, 32'h0);
    check("rst_done", {31'b0, done_out}, 32'h0);
    check("rst_out", floating_division_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done_out || busy_out) done_cnt++;
    end
    check("rst_no_activity", done_cnt, 0);
    run_op(32'h40C00000, 32'h40000000, res, lat);
    check("post_rst_result", res, 32'h40400000);
    check("post_rst_latency", lat, 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
